btn_debounce_pulse: RTL and testbench



---
 rtl/btn_debounce_pulse.sv | 129 ++++++++++++
 tb/tb_btn_debounce_pulse.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_pulse.sv
// ---------------------------------------------------------------------------
// btn_debounce_pulse
//
// Cleans a bouncing, asynchronous push-button input. The raw level is
// brought into the clk domain through a two-flop synchronizer, then a
// four-state FSM requires DEBOUNCE_CYCLES consecutive synchronized samples
// of the opposite level before it accepts a change. Each accepted change
// updates level_out and emits one single-cycle pulse, so a downstream
// counter advances exactly once per physical press.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-high reset
//   btn_in         raw asynchronous button level, 1 = pressed
//   level_out      debounced button level (registered)
//   press_pulse    one-cycle pulse on an accepted 0->1 change (registered)
//   release_pulse  one-cycle pulse on an accepted 1->0 change (registered)
//
// Parameters:
//   DEBOUNCE_CYCLES  samples of the new level required, >= 2
//   CNT_W            stability counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
// Handshake: none. btn_in is a free-running level, the outputs are
// free-running registered signals with no valid/ready semantics.
// ---------------------------------------------------------------------------
module btn_debounce_pulse #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic level_out,
  output logic press_pulse,
  output logic release_pulse
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,  // stable low
    CHK_HIGH = 2'd1,  // candidate high, counting
    HIGH     = 2'd2,  // stable high
    CHK_LOW  = 2'd3   // candidate low, counting
  } state_t;

  // The counter sits at DEBOUNCE_CYCLES-1 on the sample that completes the
  // run, so it never needs to hold DEBOUNCE_CYCLES itself.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             s1;
  logic             btn_s;

  // Two-flop synchronizer; only btn_s is seen by the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      s1    <= btn_in;
      btn_s <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      level_out     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      // Pulses last exactly one cycle unless re-asserted below.
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_s) begin
            state <= CHK_HIGH;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        CHK_HIGH: begin
          if (!btn_s) begin
            // Bounce: restart from the stable low state.
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= HIGH;
            level_out   <= 1'b1;
            press_pulse <= 1'b1;
            cnt         <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          if (!btn_s) begin
            state <= CHK_LOW;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        CHK_LOW: begin
          if (btn_s) begin
            state <= HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state         <= IDLE;
            level_out     <= 1'b0;
            release_pulse <= 1'b1;
            cnt           <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// ---------------------------------------------------------------------------
// tb_btn_debounce_pulse
//
// Self-checking bench for btn_debounce_pulse with DEBOUNCE_CYCLES = 4.
// The reference model keeps a history of raw samples (to reproduce the
// two-edge synchronizer delay) and a history of the samples the debouncer
// sees; a change is accepted when the last D seen samples all differ from
// the current debounced level.
// ---------------------------------------------------------------------------
module tb_btn_debounce_pulse;

  localparam int D = 4;

  // ---------------- clock / reset block ----------------
  logic clk = 1'b0;
  logic reset;
  logic btn_in;
  logic level_out;
  logic press_pulse;
  logic release_pulse;

  always #5 clk = ~clk;

  btn_debounce_pulse #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_in       (btn_in),
    .level_out    (level_out),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  // ---------------- scoreboard / reference model ----------------
  int   n_checks = 0;
  int   n_fail   = 0;
  logic raw_q[$];   // raw btn_in samples, newest last
  logic seen_q[$];  // samples as seen by the debouncer, newest last
  logic m_level;
  logic m_press;
  logic m_release;
  logic [2:0] exp_q[$]; // expected {level, press, release} per cycle

  // Drive one cycle of inputs, advance the model on the edge, then wait
  // 1 time unit so outputs are sampled away from the edge.
  task automatic step(input logic b, input logic r);
    logic seen;
    logic all_diff;
    btn_in = b;
    reset  = r;
    @(posedge clk);
    m_press   = 1'b0;
    m_release = 1'b0;
    if (r) begin
      raw_q.delete();
      raw_q.push_back(1'b0);
      raw_q.push_back(1'b0);
      seen_q.delete();
      m_level = 1'b0;
    end else begin
      seen = raw_q[raw_q.size() - 2];
      raw_q.push_back(b);
      if (raw_q.size() > 2) void'(raw_q.pop_front());
      seen_q.push_back(seen);
      if (seen_q.size() > D) void'(seen_q.pop_front());
      if (seen_q.size() == D) begin
        all_diff = 1'b1;
        for (int i = 0; i < D; i++)
          if (seen_q[i] == m_level) all_diff = 1'b0;
        if (all_diff) begin
          m_level = ~m_level;
          if (m_level) m_press = 1'b1;
          else         m_release = 1'b1;
          seen_q.delete();
        end
      end
    end
    exp_q.push_back({m_level, m_press, m_release});
    #1;
  endtask

  task automatic go_idle();
    step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int press_at = -1;
    int n_press  = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      n_checks++;
      if ({level_out, press_pulse, release_pulse} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_hold cyc %0d: got %b expected 000", i,
                 {level_out, press_pulse, release_pulse});
      end
    end
    // Button held through reset release: a fresh press.
    for (int e = 0; e < 12; e++) begin
      step(1'b1, 1'b0);
      if (e == 0) begin
        n_checks++;
        if ({level_out, press_pulse, release_pulse} !== 3'b000) begin
          n_fail++;
          $display("FAIL reset_after: got %b expected 000",
                   {level_out, press_pulse, release_pulse});
        end
      end
      n_checks++;
      if ({level_out, press_pulse, release_pulse} !== exp_q[$]) begin
        n_fail++;
        $display("FAIL reset_model e %0d: got %b expected %b", e,
                 {level_out, press_pulse, release_pulse}, exp_q[$]);
      end
      if (press_pulse) begin
        n_press++;
        if (press_at < 0) press_at = e;
      end
    end
    n_checks++;
    if (press_at !== 5 || n_press !== 1) begin
      n_fail++;
      $display("FAIL reset_held_press: got at %0d count %0d expected at 5 count 1",
               press_at, n_press);
    end
  endtask

  task automatic test_clean_press();
    int n_press = 0;
    go_idle();
    for (int e = 0; e < 20; e++) begin
      step(1'b1, 1'b0);
      n_checks++;
      if ({level_out, press_pulse, release_pulse} !== exp_q[$]) begin
        n_fail++;
        $display("FAIL clean_press_model e %0d: got %b expected %b", e,
                 {level_out, press_pulse, release_pulse}, exp_q[$]);
      end
      if (press_pulse) n_press++;
      if (e == 4 || e == 5 || e == 6) begin
        n_checks++;
        if ({level_out, press_pulse} !== ((e == 4) ? 2'b00 : (e == 5) ? 2'b11 : 2'b10)) begin
          n_fail++;
          $display("FAIL clean_press_edge e %0d: got level %b press %b", e,
                   level_out, press_pulse);
        end
      end
    end
    n_checks++;
    if (n_press !== 1) begin
      n_fail++;
      $display("FAIL clean_press_count: got %0d expected 1", n_press);
    end
  endtask

  task automatic test_bounce();
    logic [5:0] pat = 6'b101101; // applied LSB first: 1,0,1,1,0,1
    int press_at = -1;
    int n_press  = 0;
    logic b;
    go_idle();
    for (int e = 0; e < 20; e++) begin
      b = (e < 6) ? pat[e] : 1'b1;
      step(b, 1'b0);
      n_checks++;
      if ({level_out, press_pulse, release_pulse} !== exp_q[$]) begin
        n_fail++;
        $display("FAIL bounce_model e %0d: got %b expected %b", e,
                 {level_out, press_pulse, release_pulse}, exp_q[$]);
      end
      if (press_pulse) begin
        n_press++;
        if (press_at < 0) press_at = e;
      end
    end
    // Last raw 0 at edge 4 -> btn_s settles high after edge 6 -> press at 10.
    n_checks++;
    if (press_at !== 10 || n_press !== 1) begin
      n_fail++;
      $display("FAIL bounce_press: got at %0d count %0d expected at 10 count 1",
               press_at, n_press);
    end
  endtask

  task automatic test_glitch();
    int n_bad = 0;
    go_idle();
    for (int e = 0; e < 15; e++) begin
      step((e < 3) ? 1'b1 : 1'b0, 1'b0);
      if ({level_out, press_pulse, release_pulse} !== 3'b000) n_bad++;
      n_checks++;
      if ({level_out, press_pulse, release_pulse} !== exp_q[$]) begin
        n_fail++;
        $display("FAIL glitch_model e %0d: got %b expected %b", e,
                 {level_out, press_pulse, release_pulse}, exp_q[$]);
      end
    end
    n_checks++;
    if (n_bad !== 0) begin
      n_fail++;
      $display("FAIL glitch_quiet: got %0d active cycles expected 0", n_bad);
    end
  endtask

  task automatic test_release();
    int rel_at  = -1;
    int n_rel   = 0;
    int n_press = 0;
    go_idle();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    n_checks++;
    if (level_out !== 1'b1) begin
      n_fail++;
      $display("FAIL release_setup: got level %b expected 1", level_out);
    end
    for (int e = 0; e < 15; e++) begin
      step(1'b0, 1'b0);
      n_checks++;
      if ({level_out, press_pulse, release_pulse} !== exp_q[$]) begin
        n_fail++;
        $display("FAIL release_model e %0d: got %b expected %b", e,
                 {level_out, press_pulse, release_pulse}, exp_q[$]);
      end
      if (press_pulse) n_press++;
      if (release_pulse) begin
        n_rel++;
        if (rel_at < 0) rel_at = e;
      end
      if (e == 4 || e == 5) begin
        n_checks++;
        if (level_out !== ((e == 4) ? 1'b1 : 1'b0)) begin
          n_fail++;
          $display("FAIL release_level e %0d: got %b", e, level_out);
        end
      end
    end
    n_checks++;
    if (rel_at !== 5 || n_rel !== 1 || n_press !== 0) begin
      n_fail++;
      $display("FAIL release_pulse: got at %0d rel %0d press %0d expected at 5 rel 1 press 0",
               rel_at, n_rel, n_press);
    end
  endtask

  task automatic test_reset_mid();
    int press_at = -1;
    int n_press  = 0;
    go_idle();
    // Edges 0..3 with btn high leave the debouncer mid-count (cnt = 2).
    for (int e = 0; e < 4; e++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    n_checks++;
    if ({level_out, press_pulse, release_pulse} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid_during: got %b expected 000",
               {level_out, press_pulse, release_pulse});
    end
    for (int e = 0; e < 15; e++) begin
      step(1'b1, 1'b0);
      n_checks++;
      if ({level_out, press_pulse, release_pulse} !== exp_q[$]) begin
        n_fail++;
        $display("FAIL reset_mid_model e %0d: got %b expected %b", e,
                 {level_out, press_pulse, release_pulse}, exp_q[$]);
      end
      if (press_pulse) begin
        n_press++;
        if (press_at < 0) press_at = e;
      end
    end
    n_checks++;
    if (press_at !== 5 || n_press !== 1) begin
      n_fail++;
      $display("FAIL reset_mid_press: got at %0d count %0d expected at 5 count 1",
               press_at, n_press);
    end
  endtask

  task automatic test_random();
    int   cyc = 0;
    int   run;
    logic b;
    logic r;
    go_idle();
    while (cyc < 600) begin
      b   = 1'($urandom_range(0, 1));
      run = (($urandom_range(0, 3) == 0) ? $urandom_range(5, 12) : $urandom_range(1, 5));
      for (int k = 0; k < run; k++) begin
        r = ($urandom_range(0, 79) == 0);
        step(b, r);
        cyc++;
        n_checks++;
        if ({level_out, press_pulse, release_pulse} !== exp_q[$]) begin
          n_fail++;
          $display("FAIL random_model cyc %0d: got %b expected %b", cyc,
                   {level_out, press_pulse, release_pulse}, exp_q[$]);
        end
        if (press_pulse && release_pulse) begin
          n_fail++;
          $display("FAIL random_both_pulses cyc %0d: got 11 expected not both", cyc);
        end
      end
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    btn_in = 1'b0;
    reset  = 1'b1;
    raw_q.push_back(1'b0);
    raw_q.push_back(1'b0);
    m_level   = 1'b0;
    m_press   = 1'b0;
    m_release = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_release();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
